nb_line_buf_ctrl: RTL and testbench
===================================

Name: nb_line_buf_ctrl

Overview:
- Sequencer that owns the single-port neighbour-info RAM. That RAM holds one 4x4-unit entry per picture column: intra pred mode, ref_idx and mvp info for the row above.
- Before a CU is decoded, it fetches the above-left, above and above-right entries and streams them to the prediction stage with availability flags.
- After the CU is decoded, it writes the CU's bottom-row info back into the RAM.
- It serialises read and write traffic and absorbs the RAM's 1-cycle read latency.

Parameters:
addr_bits, 8, RAM address width; picture width in 4x4 units must be at most 2^addr_bits
data_bits, 16, width of one neighbour-info entry

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pic_w4  input  addr_bits+1  picture width in 4x4 units; static during a picture
fetch_start  input  1  one-cycle pulse: start a fetch
fetch_x4  input  addr_bits  CU left column in 4x4 units
fetch_w4  input  5  CU width in 4x4 units, 1..16
fetch_valid  output  1  fetch_data, fetch_avail and fetch_idx valid this cycle
fetch_idx  output  5  0 = above-left, 1..w4 = above, w4+1 = above-right
fetch_data  output  data_bits  neighbour entry; 0 when not available
fetch_avail  output  1  entry lies inside the picture
fetch_done  output  1  one-cycle pulse, coincident with the last fetch_valid
store_start  input  1  one-cycle pulse: start write-back
store_x4  input  addr_bits  CU left column
store_w4  input  5  number of entries to write, 1..16
store_valid  input  1  store_data valid
store_data  input  data_bits  entry for the next column
store_ready  output  1  controller accepts store_data this cycle
store_done  output  1  one-cycle pulse after the last write
busy  output  1  high whenever the FSM is not in IDLE
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  addr_bits  RAM address
ram_din  output  data_bits  RAM write data
ram_dout  input  data_bits  RAM read data; valid 1 cycle after ram_en with ram_we low

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters cleared. Reset asserted mid-operation aborts the transfer immediately, with no further RAM access. The RAM contents are not cleared.
- States: IDLE, RD, RD_LAST, WR, and one-cycle DONE pulse logic.
- IDLE:
  - store_start has priority over a simultaneous fetch_start, so write-back always precedes the next read. The dropped fetch_start is not queued.
  - fetch_start latches x4/w4, clears counter k=0, and moves to RD.
  - store_start latches x4/w4 and moves to WR.
  - Start pulses while busy are ignored.
- RD: issues one request per cycle, k = 0 .. w4+1.
  - Column c = x4 - 1 + k, computed in addr_bits+1 signed width.
  - Request k is in-picture when 0 <= c < pic_w4. Then ram_en=1, ram_we=0, ram_addr=c[addr_bits-1:0].
  - Out-of-picture requests hold ram_en=0; no RAM access.
  - After request w4+1, go to RD_LAST.
- Read return (1-cycle latency): fetch_valid is asserted the cycle after request k, with fetch_idx=k. If in-picture, fetch_avail=1 and fetch_data=ram_dout; otherwise fetch_avail=0 and fetch_data=0.
- RD_LAST: emits the final fetch_valid with fetch_done=1, then returns to IDLE.
- Fetch timing: total latency from fetch_start to fetch_done is w4+3 cycles. Outputs are contiguous, with no gaps.
- WR:
  - store_ready=1.
  - On store_valid && store_ready: ram_en=1, ram_we=1, ram_addr=x4+j, ram_din=store_data; j increments.
  - store_valid low stalls the write; nothing is issued.
  - Writes with x4+j >= pic_w4 are accepted (handshake completes) but suppressed (ram_en=0).
  - After j reaches w4, store_ready drops, store_done pulses for one cycle, and the FSM returns to IDLE.
- busy is high from the cycle after an accepted start until the cycle after fetch_done or store_done.
- A fetch_start in the same cycle as store_done is ignored (busy is still high). The earliest accepted fetch_start is the cycle after busy falls.
- The RAM port is never driven by read and write in the same cycle.

Test Plan:
- Reset, pic_w4=20, write columns 0..19 with data 0x100+col; fetch x4=4, w4=2 -> fetch_valid for 4 consecutive cycles, data 0x103, 0x104, 0x105, 0x106, all avail=1; fetch_done on the 4th; start-to-done latency 5 cycles.
- Left edge: fetch x4=0, w4=4 -> idx0 has avail=0, data=0 and no ram_en in its request cycle; idx1..5 return 0x100..0x104.
- Right edge: fetch x4=16, w4=4 -> idx5 (column 20) avail=0, data=0; idx0..4 return 0x10F..0x113.
- Store with store_valid gaps: x4=8, w4=4, data A..D, valid low for 2 cycles mid-stream -> exactly 4 writes to addresses 8..11; a following fetch returns A..D at idx1..4.
- Simultaneous fetch_start and store_start in IDLE -> write executes, fetch is dropped, busy is high throughout; a start during busy is ignored.
- rst_n low during RD after 2 requests -> all outputs 0 immediately, no further ram_en; a new fetch after reset completes normally.

Source files
------------

// File: rtl/nb_line_buf_ctrl.sv
// nb_line_buf_ctrl: sequences above-row neighbour fetches and CU bottom-row
// write-backs over a single-port neighbour-info RAM with 1-cycle read latency.
module nb_line_buf_ctrl #(
    parameter int addr_bits = 8,
    parameter int data_bits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addr_bits:0]   pic_w4,
    input  logic                 fetch_start,
    input  logic [addr_bits-1:0] fetch_x4,
    input  logic [4:0]           fetch_w4,
    output logic                 fetch_valid,
    output logic [4:0]           fetch_idx,
    output logic [data_bits-1:0] fetch_data,
    output logic                 fetch_avail,
    output logic                 fetch_done,
    input  logic                 store_start,
    input  logic [addr_bits-1:0] store_x4,
    input  logic [4:0]           store_w4,
    input  logic                 store_valid,
    input  logic [data_bits-1:0] store_data,
    output logic                 store_ready,
    output logic                 store_done,
    output logic                 busy,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [addr_bits-1:0] ram_addr,
    output logic [data_bits-1:0] ram_din,
    input  logic [data_bits-1:0] ram_dout
);
    localparam int cw = addr_bits + 2;

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, WR_DONE} state_t;

    state_t               state, state_nx;
    logic [addr_bits-1:0] x4;
    logic [4:0]           w4, k, j, rd_k;
    logic                 rd_v, rd_in;
    logic [cw-1:0]        col, wcol;
    logic                 col_in, wr_in, wr_go;

    // Column x4-1+k goes negative at the left edge; the extra top bit flags that.
    assign col    = {2'b00, x4} + {{(cw-5){1'b0}}, k} - cw'(1);
    assign col_in = !col[cw-1] && col < {1'b0, pic_w4};
    assign wcol   = {2'b00, x4} + {{(cw-5){1'b0}}, j};
    assign wr_in  = wcol < {1'b0, pic_w4};
    assign wr_go  = state == WR && store_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x4    <= '0;
            w4    <= '0;
            k     <= '0;
            j     <= '0;
            rd_v  <= 1'b0;
            rd_k  <= '0;
            rd_in <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && store_start) begin
                x4 <= store_x4;
                w4 <= store_w4;
                j  <= '0;
            end else if (state == IDLE && fetch_start) begin
                x4 <= fetch_x4;
                w4 <= fetch_w4;
                k  <= '0;
            end
            if (state == RD)
                k <= k + 5'd1;
            if (wr_go)
                j <= j + 5'd1;
            rd_v  <= state == RD;
            rd_k  <= k;
            rd_in <= state == RD && col_in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = store_start ? WR : fetch_start ? RD : IDLE;
            RD:      state_nx = k == w4 + 5'd1 ? RD_LAST : RD;
            RD_LAST: state_nx = IDLE;
            WR:      state_nx = wr_go && j == w4 - 5'd1 ? WR_DONE : WR;
            WR_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = state != IDLE;
    assign store_ready = state == WR;
    assign store_done  = state == WR_DONE;
    assign ram_we      = wr_go && wr_in;
    assign ram_en      = (state == RD && col_in) || ram_we;
    assign ram_addr    = state == RD ? col[addr_bits-1:0] : state == WR ? wcol[addr_bits-1:0] : '0;
    assign ram_din     = ram_we ? store_data : '0;
    assign fetch_valid = rd_v;
    assign fetch_idx   = rd_v ? rd_k : '0;
    assign fetch_avail = rd_in;
    assign fetch_data  = rd_in ? ram_dout : '0;
    assign fetch_done  = rd_v && state == RD_LAST;
endmodule

// File: tb/tb_nb_line_buf_ctrl.sv
// tb_nb_line_buf_ctrl: scoreboard bench with a behavioural RAM and golden column image.
module tb_nb_line_buf_ctrl;
    logic        clk = 0, rst_n = 0;
    logic [8:0]  pic_w4 = 9'd20;
    logic        fetch_start = 0, store_start = 0, store_valid = 0;
    logic [7:0]  fetch_x4 = 0, store_x4 = 0;
    logic [4:0]  fetch_w4 = 0, store_w4 = 0;
    logic [15:0] store_data = 0;
    logic        fetch_valid, fetch_avail, fetch_done, store_ready, store_done, busy, ram_en, ram_we;
    logic [4:0]  fetch_idx;
    logic [15:0] fetch_data, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    nb_line_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pic_w4(pic_w4),
        .fetch_start(fetch_start), .fetch_x4(fetch_x4), .fetch_w4(fetch_w4),
        .fetch_valid(fetch_valid), .fetch_idx(fetch_idx), .fetch_data(fetch_data),
        .fetch_avail(fetch_avail), .fetch_done(fetch_done),
        .store_start(store_start), .store_x4(store_x4), .store_w4(store_w4),
        .store_valid(store_valid), .store_data(store_data), .store_ready(store_ready),
        .store_done(store_done), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    logic [15:0] gold [0:255];
    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else ram_dout <= mem[ram_addr];
        end

    int errors = 0, checks = 0, rd_bad = 0;
    int pic = 20;
    logic [20:0] fq [$];
    logic [23:0] wq [$];
    logic [20:0] ef;
    logic [23:0] ew;
    logic [63:0] outs;
    assign outs = {fetch_valid, fetch_done, store_ready, store_done, busy, ram_en, ram_we,
                   fetch_avail, fetch_idx, fetch_data, ram_addr, ram_din};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            if (fetch_valid) begin
                if (fq.size() == 0) chk("fetch_extra", 1, 0);
                else begin
                    ef = fq.pop_front();
                    chk("fetch", {fetch_idx, fetch_avail, fetch_data}, ef);
                end
            end
            if (ram_en && ram_we) begin
                if (wq.size() == 0) chk("write_extra", 1, 0);
                else begin
                    ew = wq.pop_front();
                    chk("write", {ram_addr, ram_din}, ew);
                end
            end
            if (ram_en && !ram_we && {1'b0, ram_addr} >= pic_w4) rd_bad++;
        end

    task automatic push_fetch(input int x, input int w);
        for (int i = 0; i <= w + 1; i++) begin
            int c = x - 1 + i;
            bit a = c >= 0 && c < pic;
            fq.push_back({5'(i), a, a ? gold[c] : 16'h0});
        end
    endtask

    task automatic do_fetch(input int x, input int w);
        int lat = -1;
        @(posedge clk); #1;
        fetch_start = 1; fetch_x4 = 8'(x); fetch_w4 = 5'(w);
        push_fetch(x, w);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_done && lat < 0) lat = i;
            @(posedge clk); #1;
            fetch_start = 0;
            if (lat >= 0) break;
        end
        chk("fetch_lat", 64'(lat), 64'(w + 3));
        chk("fetch_drain", 64'(fq.size()), 0);
    endtask

    task automatic do_store(input int x, input int w, input int gap, input bit with_fetch, input logic [15:0] base);
        int sent = 0, gc = 0, t = 0, pushed = -1;
        bit acc, found = 0;
        @(posedge clk); #1;
        store_start = 1; store_x4 = 8'(x); store_w4 = 5'(w);
        fetch_start = with_fetch; fetch_x4 = 8'(x); fetch_w4 = 5'(w);
        @(posedge clk); #1;
        store_start = 0; fetch_start = 0;
        chk("store_busy", busy, 1);
        while (sent < w && t < 100) begin
            if (sent == gap && gc < 2) begin
                store_valid = 0;
                gc++;
            end else begin
                store_valid = 1;
                store_data = base + 16'(sent);
                if (pushed != sent) begin
                    pushed = sent;
                    if (x + sent < pic) begin
                        wq.push_back({8'(x + sent), store_data});
                        gold[x + sent] = store_data;
                    end
                end
            end
            fetch_start = with_fetch && t == 1;
            fetch_x4 = 8'(x); fetch_w4 = 5'(w);
            @(negedge clk);
            acc = store_valid && store_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            t++;
        end
        store_valid = 0; fetch_start = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (store_done) begin found = 1; break; end
        end
        chk("store_done", found, 1);
        @(posedge clk); #1;
        chk("store_idle", busy, 0);
        chk("write_drain", 64'(wq.size()), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs, 0);
        @(posedge clk); #1 rst_n = 1;
        do_store(0, 16, 99, 0, 16'h100);
        do_store(16, 4, 99, 0, 16'h110);
        do_fetch(4, 2);
        do_fetch(0, 4);
        do_fetch(16, 4);
        do_store(8, 4, 2, 0, 16'hA000);
        do_fetch(8, 4);
        do_store(12, 2, 99, 1, 16'hB000);
        repeat (5) @(posedge clk);
        do_fetch(11, 3);
        do_store(18, 4, 99, 0, 16'hC000);
        do_fetch(17, 3);
        // abort a fetch after two requests have gone out
        @(posedge clk); #1;
        fetch_start = 1; fetch_x4 = 8'd4; fetch_w4 = 5'd8;
        push_fetch(4, 8);
        @(posedge clk); #1 fetch_start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 0;
        #1 chk("abort_outs", outs, 0);
        fq.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_ram_en", ram_en, 0);
        end
        @(posedge clk); #1 rst_n = 1;
        do_fetch(4, 2);
        repeat (3) @(posedge clk);
        chk("rd_oob", 64'(rd_bad), 0);
        chk("q_empty", 64'(fq.size() + wq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
